euler_result_tx: RTL and testbench

- Consumer end of the solver result interface: watches a solver's isEnd/sum outputs and latches sum on the rising edge of isEnd.
- Converts the latched value to unsigned decimal ASCII and streams it byte-by-byte over a valid/ready byte interface, terminated by a newline.
- Sits between any pN solver block and a UART transmitter or bench byte sink, so results can leave the chip without a simulator $display.

---
 rtl/euler_result_tx.sv | 132 +++++++++++++
 tb/tb_euler_result_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/euler_result_tx.sv
// rtl/euler_result_tx.sv - latch a solver result on isEnd rise and stream it as decimal ASCII plus newline
module euler_result_tx #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             isEnd,
    input  logic [WIDTH-1:0] sum,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

    localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_SEND,
        S_NL,
        S_DONE
    } state_t;

    state_t              state;
    logic                isend_q;
    logic [WIDTH-1:0]    bin_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [CW-1:0]       cnt_q;
    logic [PW-1:0]       ptr_q;

    logic [4*DIGITS-1:0] bcd_adj;
    logic [4*DIGITS-1:0] bcd_next;
    logic [PW-1:0]       msnz;

    function automatic logic [3:0] nib(input logic [4*DIGITS-1:0] v, input logic [PW-1:0] p);
        return v[{p, 2'b00} +: 4];
    endfunction

    function automatic logic [7:0] ascii(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // One double-dabble step, plus the leading-digit search on its result
    // (only consumed on the final conversion step).
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
        msnz = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_next[4*i +: 4] != 4'd0) begin
                msnz = PW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            isend_q  <= 1'b1;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            isend_q <= isEnd;
            case (state)
                S_IDLE: begin
                    if (isEnd && !isend_q) begin
                        bin_q <= sum;
                        bcd_q <= '0;
                        cnt_q <= '0;
                        busy  <= 1'b1;
                        state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    bcd_q <= bcd_next;
                    bin_q <= {bin_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        ptr_q    <= msnz;
                        tx_data  <= ascii(nib(bcd_next, msnz));
                        tx_valid <= 1'b1;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (ptr_q == '0) begin
                            tx_data <= 8'h0A;
                            state   <= S_NL;
                        end else begin
                            ptr_q   <= ptr_q - 1'b1;
                            tx_data <= ascii(nib(bcd_q, ptr_q - 1'b1));
                        end
                    end
                end
                S_NL: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_data  <= 8'h00;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Re-arm only once the solver drops its completion level.
                    if (!isEnd) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_euler_result_tx.sv
// tb/tb_euler_result_tx.sv - directed self-checking bench for euler_result_tx
module tb_euler_result_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        isEnd;
    logic [31:0] sum;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    euler_result_tx #(.WIDTH(32), .DIGITS(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .isEnd    (isEnd),
        .sum      (sum),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic report(input string tag, input logic [31:0] v, input string digits,
                          input bit toggle, input bit chg);
        int         cyc;
        int         idx;
        int         span;
        bit         stalled;
        logic [7:0] held;
        logic [7:0] expb;
        @(negedge clk);
        sum      = v;
        isEnd    = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (chg) sum = 32'd99;
        chk({tag, "_busy"}, busy, 1'b1);
        cyc = 0;
        while (!tx_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 32);
        idx     = 0;
        span    = 0;
        stalled = 1'b0;
        held    = 8'h00;
        while (idx < digits.len() + 1 && span < 200) begin
            chk({tag, "_valid"}, tx_valid, 1'b1);
            if (stalled) chk({tag, "_stable"}, tx_data, held);
            tx_ready = toggle ? (span % 3 == 0) : 1'b1;
            if (tx_ready) begin
                expb = (idx < digits.len()) ? digits[idx] : 8'h0A;
                chk({tag, "_byte"}, tx_data, expb);
                idx++;
                stalled = 1'b0;
            end else begin
                held    = tx_data;
                stalled = 1'b1;
            end
            span++;
            @(negedge clk);
        end
        if (!toggle) chk({tag, "_span"}, span, digits.len() + 1);
        chk({tag, "_count"}, idx, digits.len() + 1);
        chk({tag, "_valid_end"}, tx_valid, 1'b0);
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_done_end"}, done, 1'b1);
    endtask

    task automatic drop(input string tag);
        @(negedge clk);
        isEnd = 1'b0;
        @(negedge clk);
        chk({tag, "_done_clr"}, done, 1'b0);
    endtask

    initial begin
        int seen;
        reset    = 1'b0;
        isEnd    = 1'b0;
        sum      = 32'd0;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        report("r233168", 32'd233168, "233168", 1'b0, 1'b1);

        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_valid || !done) seen++;
        end
        chk("hold_high_quiet", seen, 0);
        drop("r233168");

        report("r99", 32'd99, "99", 1'b0, 1'b0);
        drop("r99");
        report("r0", 32'd0, "0", 1'b0, 1'b0);
        drop("r0");
        report("rmax", 32'hFFFFFFFF, "4294967295", 1'b0, 1'b0);
        drop("rmax");
        report("r1000", 32'd1000, "1000", 1'b1, 1'b0);
        drop("r1000");

        // Reset while the third digit is on offer.
        @(negedge clk);
        sum      = 32'd233168;
        isEnd    = 1'b1;
        tx_ready = 1'b1;
        seen     = 0;
        while (!tx_valid && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        @(negedge clk);
        @(negedge clk);
        chk("mid_third_digit", tx_data, 8'h33);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", tx_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        seen  = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_valid || busy) seen++;
        end
        chk("post_rst_quiet", seen, 0);
        @(negedge clk);
        isEnd = 1'b0;
        @(negedge clk);
        report("r5", 32'd5, "5", 1'b0, 1'b0);
        drop("r5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
